// File: rtl/tournament_bp_update_pkg.sv
// tournament_bp_update_pkg: shared record type, table sizes and saturating counter step
package tournament_bp_update_pkg;
  localparam int unsigned ChoicePredictorIndexBits = 10;
  localparam int unsigned GlobalPredictorIndexBits = 10;
  localparam int unsigned LocalPredictorIndexBits = 10;
  localparam int unsigned ChoiceCtrWidth = 2;
  localparam int unsigned GlobalCtrWidth = 2;
  localparam int unsigned LocalCtrWidth = 2;
  localparam int unsigned SatW = 16;
  typedef struct packed {
    logic taken;
    logic gpred;
    logic lpred;
    logic [ChoicePredictorIndexBits-1:0] cidx;
    logic [GlobalPredictorIndexBits-1:0] gidx;
    logic [LocalPredictorIndexBits-1:0] lidx;
  } bp_resolve_t;
  typedef enum logic [1:0] {IDLE, READ, MODIFY, WRITE} bp_upd_state_e;
  function automatic logic [SatW-1:0] sat_step(input logic [SatW-1:0] v, input logic up,
                                                input logic dn, input int unsigned bits);
    logic [SatW-1:0] max;
    max = SatW'((32'd1 << bits) - 32'd1);
    return up ? (v == max ? v : v + SatW'(1)) : dn ? (v == '0 ? v : v - SatW'(1)) : v;
  endfunction
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: synchronous FIFO with occupancy count and optional fall-through
module fifo_v3 #(
  parameter bit FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH = 4,
  parameter type dtype = logic,
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  output logic         full_o,
  output logic         empty_o,
  output logic [AddrW:0] usage_o,
  input  dtype         data_i,
  input  logic         push_i,
  output dtype         data_o,
  input  logic         pop_i
);
  dtype mem [DEPTH];
  logic [AddrW-1:0] rd_ptr, wr_ptr;
  logic push_ok, pop_ok;
  assign full_o = usage_o == (AddrW+1)'(DEPTH);
  assign empty_o = usage_o == '0 && !(FALL_THROUGH && push_i);
  assign data_o = (FALL_THROUGH && usage_o == '0) ? data_i : mem[rd_ptr];
  assign push_ok = push_i && !full_o;
  assign pop_ok = pop_i && !empty_o;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      usage_o <= '0;
    end else begin
      rd_ptr <= pop_ok ? rd_ptr + AddrW'(1) : rd_ptr;
      wr_ptr <= push_ok ? wr_ptr + AddrW'(1) : wr_ptr;
      usage_o <= usage_o + (AddrW+1)'(push_ok) - (AddrW+1)'(pop_ok);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= data_i;
  end
endmodule

// File: rtl/tournament_bp_update.sv
// tournament_bp_update: queued read-modify-write of the tournament predictor counter tables
module tournament_bp_update
  import tournament_bp_update_pkg::*;
#(
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned ChoiceIdxBits = ChoicePredictorIndexBits,
  parameter int unsigned GlobalIdxBits = GlobalPredictorIndexBits,
  parameter int unsigned LocalIdxBits = LocalPredictorIndexBits,
  parameter int unsigned ChoiceCtrBits = ChoiceCtrWidth,
  parameter int unsigned GlobalCtrBits = GlobalCtrWidth,
  parameter int unsigned LocalCtrBits = LocalCtrWidth
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     resolve_valid_i,
  output logic                     resolve_ready_o,
  input  logic                     resolve_taken_i,
  input  logic                     resolve_gpred_i,
  input  logic                     resolve_lpred_i,
  input  logic [ChoiceIdxBits-1:0] resolve_cidx_i,
  input  logic [GlobalIdxBits-1:0] resolve_gidx_i,
  input  logic [LocalIdxBits-1:0]  resolve_lidx_i,
  output logic                     tbl_rd_req_o,
  input  logic                     tbl_rd_gnt_i,
  output logic [ChoiceIdxBits-1:0] choice_rd_idx_o,
  output logic [GlobalIdxBits-1:0] global_rd_idx_o,
  output logic [LocalIdxBits-1:0]  local_rd_idx_o,
  input  logic [ChoiceCtrBits-1:0] choice_rd_data_i,
  input  logic [GlobalCtrBits-1:0] global_rd_data_i,
  input  logic [LocalCtrBits-1:0]  local_rd_data_i,
  output logic                     choice_we_o,
  output logic                     global_we_o,
  output logic                     local_we_o,
  output logic [ChoiceIdxBits-1:0] choice_wr_idx_o,
  output logic [GlobalIdxBits-1:0] global_wr_idx_o,
  output logic [LocalIdxBits-1:0]  local_wr_idx_o,
  output logic [ChoiceCtrBits-1:0] choice_wr_data_o,
  output logic [GlobalCtrBits-1:0] global_wr_data_o,
  output logic [LocalCtrBits-1:0]  local_wr_data_o,
  output logic                     busy_o
);
  localparam int unsigned UsageW = $clog2(QueueDepth) + 1;
  bp_resolve_t rec_in, head;
  bp_upd_state_e state;
  logic full, empty, push, pop, c_up, c_dn, c_we_q, g_we_q, l_we_q;
  logic [UsageW-1:0] usage;
  logic [ChoiceCtrBits-1:0] c_new;
  logic [GlobalCtrBits-1:0] g_new;
  logic [LocalCtrBits-1:0] l_new;
  assign rec_in = '{taken: resolve_taken_i, gpred: resolve_gpred_i, lpred: resolve_lpred_i,
                    cidx: resolve_cidx_i, gidx: resolve_gidx_i, lidx: resolve_lidx_i};
  fifo_v3 #(
    .FALL_THROUGH(1'b0),
    .DEPTH(QueueDepth),
    .dtype(bp_resolve_t)
  ) i_queue (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .full_o(full),
    .empty_o(empty),
    .usage_o(usage),
    .data_i(rec_in),
    .push_i(push),
    .data_o(head),
    .pop_i(pop)
  );
  assign resolve_ready_o = !full;
  assign push = resolve_valid_i && !full;
  assign pop = state == WRITE;
  assign busy_o = !empty || state != IDLE;
  assign tbl_rd_req_o = state == READ;
  assign choice_rd_idx_o = tbl_rd_req_o ? head.cidx : '0;
  assign global_rd_idx_o = tbl_rd_req_o ? head.gidx : '0;
  assign local_rd_idx_o = tbl_rd_req_o ? head.lidx : '0;
  assign c_up = head.gpred == head.taken && head.lpred != head.taken;
  assign c_dn = head.lpred == head.taken && head.gpred != head.taken;
  assign c_new = ChoiceCtrBits'(sat_step(SatW'(choice_rd_data_i), c_up, c_dn, ChoiceCtrBits));
  assign g_new = GlobalCtrBits'(sat_step(SatW'(global_rd_data_i), head.taken, !head.taken, GlobalCtrBits));
  assign l_new = LocalCtrBits'(sat_step(SatW'(local_rd_data_i), head.taken, !head.taken, LocalCtrBits));
  assign choice_we_o = pop && c_we_q;
  assign global_we_o = pop && g_we_q;
  assign local_we_o = pop && l_we_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      {c_we_q, g_we_q, l_we_q} <= '0;
      choice_wr_idx_o <= '0;
      global_wr_idx_o <= '0;
      local_wr_idx_o <= '0;
      choice_wr_data_o <= '0;
      global_wr_data_o <= '0;
      local_wr_data_o <= '0;
    end else begin
      unique case (state)
        IDLE: state <= empty ? IDLE : READ;
        READ: state <= tbl_rd_gnt_i ? MODIFY : READ;
        MODIFY: begin
          state <= WRITE;
          c_we_q <= c_new != choice_rd_data_i;
          g_we_q <= g_new != global_rd_data_i;
          l_we_q <= l_new != local_rd_data_i;
          choice_wr_idx_o <= head.cidx;
          global_wr_idx_o <= head.gidx;
          local_wr_idx_o <= head.lidx;
          choice_wr_data_o <= c_new;
          global_wr_data_o <= g_new;
          local_wr_data_o <= l_new;
        end
        default: state <= (usage > UsageW'(1) || push) ? READ : IDLE;
      endcase
    end
  end
endmodule
